// File: rtl/inst_fetch_if.sv
// inst_fetch_if: instruction-memory read port, branch redirect and decode handshake
// for the fetch stage. master = fetch stage view, slave = memory/decode side view.
interface inst_fetch_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_rvalid;
  logic [DATA_W-1:0] imem_rdata;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              if_valid;
  logic              if_ready;
  logic [DATA_W-1:0] if_inst;
  logic [ADDR_W-1:0] if_pc;
  logic [5:0]        if_opcode;

  modport master (
    output imem_req, imem_addr,
    input  imem_rvalid, imem_rdata,
    input  redirect_valid, redirect_pc,
    output if_valid, if_inst, if_pc, if_opcode,
    input  if_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rvalid, imem_rdata,
    output redirect_valid, redirect_pc,
    input  if_valid, if_inst, if_pc, if_opcode,
    output if_ready
  );
endinterface

// File: rtl/inst_fetch.sv
// inst_fetch: PC keeper, single-outstanding instruction-memory reader, small
// instruction FIFO feeding decode, and branch redirect with stale-response drop.
// Optional feature macro: INST_FETCH_PERF_CNT_EN adds saturating stall/flush counters.
module inst_fetch #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int unsigned       BUF_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  inst_fetch_if.master bus
`ifdef INST_FETCH_PERF_CNT_EN
  ,
  output logic [31:0]  perf_stall_cnt,
  output logic [31:0]  perf_flush_cnt
`endif
);

  localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] inst;
  } entry_t;

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] req_pc_q;
  entry_t            fifo_q [BUF_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [CNT_W-1:0]  count_q;

  logic   redirect;
  logic   flush;
  logic   not_empty;
  logic   full;
  logic   pop;
  logic   issue;
  logic   push;
  entry_t head;

  // Handshake decisions for the current cycle; redirect overrides everything.
  assign redirect  = bus.redirect_valid;
  assign flush     = redirect && (state_q != IDLE);
  assign not_empty = (count_q != '0);
  assign full      = (count_q == CNT_W'(BUF_DEPTH));
  assign pop       = not_empty && bus.if_ready && !flush;
  assign issue     = (state_q == REQ) && !redirect && (!full || pop);
  assign push      = (state_q == WAIT) && bus.imem_rvalid && !redirect;

  // Memory request port: address is always the word-aligned PC.
  assign bus.imem_req  = issue;
  assign bus.imem_addr = pc_q & ~ADDR_W'(3);

  // Decode side: FIFO head, forced to zero while empty.
  assign head          = fifo_q[rd_ptr_q];
  assign bus.if_valid  = not_empty;
  assign bus.if_inst   = not_empty ? head.inst : '0;
  assign bus.if_pc     = not_empty ? head.pc   : '0;
  assign bus.if_opcode = bus.if_inst[DATA_W-1 -: 6];

  // Fetch FSM, PC and request-address tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
    end else begin
      if (redirect) begin
        pc_q <= bus.redirect_pc & ~ADDR_W'(3);
      end else if (issue) begin
        pc_q     <= pc_q + ADDR_W'(4);
        req_pc_q <= pc_q;
      end
      case (state_q)
        IDLE: state_q <= REQ;
        REQ: begin
          if (issue) state_q <= WAIT;
        end
        WAIT: begin
          if (bus.imem_rvalid) state_q <= REQ;
          else if (redirect)   state_q <= DROP;
        end
        DROP: begin
          if (bus.imem_rvalid) state_q <= REQ;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // FIFO pointers and occupancy; a flush empties it and ignores any same-cycle pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage; space is guaranteed because a request is only issued with room.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= '{pc: req_pc_q, inst: bus.imem_rdata};
  end

`ifdef INST_FETCH_PERF_CNT_EN
  // Saturating counters for decode starvation and redirect flushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (!not_empty && (state_q != IDLE) && (perf_stall_cnt != '1))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (redirect && (perf_flush_cnt != '1))
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed bench for inst_fetch with a single-outstanding memory model.
module tb_inst_fetch;

  logic clk;
  logic rst_n;

  inst_fetch_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef INST_FETCH_PERF_CNT_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  inst_fetch #(
    .ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0), .BUF_DEPTH(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
`ifdef INST_FETCH_PERF_CNT_EN
    , .perf_stall_cnt(perf_stall_cnt)
    , .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // memory model state
  int          lat = 1;
  bit          pend = 0;
  int          pcnt = 0;
  logic [31:0] paddr = '0;

  typedef struct {
    logic        ready;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [5:0]  op;
  } vec_t;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {6'(a[7:2] + 6'd8), a[25:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic req, input logic [31:0] addr,
                         input logic valid, input logic [31:0] pc, input logic [31:0] inst,
                         input logic [5:0] op);
    chk({tag, ".imem_req"},  32'(bus.imem_req),  32'(req));
    chk({tag, ".imem_addr"}, bus.imem_addr,      addr);
    chk({tag, ".if_valid"},  32'(bus.if_valid),  32'(valid));
    chk({tag, ".if_pc"},     bus.if_pc,          pc);
    chk({tag, ".if_inst"},   bus.if_inst,        inst);
    chk({tag, ".if_opcode"}, 32'(bus.if_opcode), 32'(op));
  endtask

  // One clock: capture any request, then drive the memory response for the next cycle.
  task automatic cycle();
    logic        rq;
    logic [31:0] ad;
    #1;
    rq = bus.imem_req;
    ad = bus.imem_addr;
    @(posedge clk);
    #1;
    bus.imem_rvalid = 1'b0;
    if (rq) begin
      pend  = 1;
      pcnt  = lat;
      paddr = ad;
    end
    if (pend) begin
      pcnt--;
      if (pcnt == 0) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = mem_word(paddr);
        pend = 0;
      end
    end
  endtask

  task automatic do_reset();
    rst_n              = 1'b0;
    bus.imem_rvalid    = 1'b0;
    bus.imem_rdata     = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.if_ready       = 1'b0;
    pend               = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  vec_t stream [8];
  int   nreq;

  initial begin
    // latency-1 streaming with decode always ready
    stream[0] = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0,        6'h00};
    stream[1] = '{1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0,        6'h00};
    stream[2] = '{1'b1, 1'b0, 32'h4, 1'b0, 32'h0, 32'h0,        6'h00};
    stream[3] = '{1'b1, 1'b1, 32'h4, 1'b1, 32'h0, 32'h20000000, 6'h08};
    stream[4] = '{1'b1, 1'b0, 32'h8, 1'b0, 32'h0, 32'h0,        6'h00};
    stream[5] = '{1'b1, 1'b1, 32'h8, 1'b1, 32'h4, 32'h24000004, 6'h09};
    stream[6] = '{1'b1, 1'b0, 32'hC, 1'b0, 32'h0, 32'h0,        6'h00};
    stream[7] = '{1'b1, 1'b1, 32'hC, 1'b1, 32'h8, 32'h28000008, 6'h0A};

    // reset values
    rst_n = 1'b0;
    bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.if_ready = 1'b0;
    #12;
    chk_out("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 6'h00);
`ifdef INST_FETCH_PERF_CNT_EN
    chk("reset.perf_stall", perf_stall_cnt, 32'h0);
    chk("reset.perf_flush", perf_flush_cnt, 32'h0);
`endif

    // table-driven stream
    lat = 1;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      bus.if_ready = stream[i].ready;
      #1;
      chk_out($sformatf("stream%0d", i), stream[i].req, stream[i].addr, stream[i].valid,
              stream[i].pc, stream[i].inst, stream[i].op);
      cycle();
    end

    // backpressure: FIFO fills with two entries, then requests stop
    lat = 1;
    do_reset();
    nreq = 0;
    cycle();
    for (int i = 1; i <= 10; i++) begin
      #1;
      if (bus.imem_req) nreq++;
      if (i >= 3) chk($sformatf("hold%0d.if_inst", i), bus.if_inst, 32'h20000000);
      cycle();
    end
    chk("hold.req_count", 32'(nreq), 32'd2);
    bus.if_ready = 1'b1;
    #1; chk_out("drain0", 1'b1, 32'h8, 1'b1, 32'h0, 32'h20000000, 6'h08); cycle();
    #1; chk_out("drain1", 1'b0, 32'hC, 1'b1, 32'h4, 32'h24000004, 6'h09); cycle();
    #1; chk_out("drain2", 1'b1, 32'hC, 1'b1, 32'h8, 32'h28000008, 6'h0A); cycle();

    // redirect in WAIT, stale response two cycles later
    lat = 3;
    do_reset();
    bus.if_ready = 1'b1;
    cycle();
    #1; chk("rdw.c1.req", 32'(bus.imem_req), 32'd1); cycle();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h103;
    #1; chk("rdw.c2.req", 32'(bus.imem_req), 32'd0); cycle();
    bus.redirect_valid = 1'b0;
    #1; chk_out("rdw.c3", 1'b0, 32'h100, 1'b0, 32'h0, 32'h0, 6'h00); cycle();
    #1; chk("rdw.c4.stale_rvalid", 32'(bus.imem_rvalid), 32'd1);
    chk("rdw.c4.valid", 32'(bus.if_valid), 32'd0); cycle();
    #1; chk_out("rdw.c5", 1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 6'h00); cycle();
    for (int i = 6; i <= 8; i++) begin
      #1; chk($sformatf("rdw.c%0d.valid", i), 32'(bus.if_valid), 32'd0); cycle();
    end
    #1; chk_out("rdw.c9", 1'b1, 32'h104, 1'b1, 32'h100, 32'h20000100, 6'h08); cycle();

    // redirect coincident with rvalid while FIFO holds data and decode pops
    lat = 1;
    do_reset();
    cycle();
    #1; chk("rdc.c1.addr", bus.imem_addr, 32'h0); cycle();
    cycle();
    #1; chk_out("rdc.c3", 1'b1, 32'h4, 1'b1, 32'h0, 32'h20000000, 6'h08); cycle();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h200; bus.if_ready = 1'b1;
    #1; chk("rdc.c4.rvalid", 32'(bus.imem_rvalid), 32'd1);
    chk("rdc.c4.req", 32'(bus.imem_req), 32'd0); cycle();
    bus.redirect_valid = 1'b0;
    #1; chk_out("rdc.c5", 1'b1, 32'h200, 1'b0, 32'h0, 32'h0, 6'h00); cycle();
    #1; chk("rdc.c6.valid", 32'(bus.if_valid), 32'd0); cycle();
    #1; chk_out("rdc.c7", 1'b1, 32'h204, 1'b1, 32'h200, 32'h20000200, 6'h08); cycle();

    // asynchronous reset mid-WAIT
    lat = 1;
    do_reset();
    repeat (4) cycle();
    #1; chk_out("arst.pre", 1'b0, 32'h8, 1'b1, 32'h0, 32'h20000000, 6'h08);
    rst_n = 1'b0; bus.imem_rvalid = 1'b0; pend = 0;
    #1; chk_out("arst.in", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 6'h00);
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    #1; chk("arst.c0.req", 32'(bus.imem_req), 32'd0); cycle();
    #1; chk("arst.c1.req", 32'(bus.imem_req), 32'd1);
    chk("arst.c1.addr", bus.imem_addr, 32'h0); cycle();

    // PC wrap at the top of the address space
    lat = 1;
    do_reset();
    bus.if_ready = 1'b1;
    cycle();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC;
    #1; chk("wrap.c1.req", 32'(bus.imem_req), 32'd0); cycle();
    bus.redirect_valid = 1'b0;
    #1; chk("wrap.c2.req", 32'(bus.imem_req), 32'd1);
    chk("wrap.c2.addr", bus.imem_addr, 32'hFFFF_FFFC); cycle();
    cycle();
    #1; chk_out("wrap.c4", 1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC, 32'h1FFF_FFFC, 6'h07); cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
